timer_arbiter: RTL

Shares the single countdown timer resource among several requesters, such as arming delay, siren duration and door-open delay, and sequences each timing job. Each job is a parameter-store lookup, a load, a countdown on the 1 Hz enable, and an expiry notification to the granted requester. The block sits between the requesters, the time-parameter store and the 1 Hz tick source. It replaces direct start_timer/interval wiring from a single FSM.

---
 rtl/timer_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/timer_arbiter.sv
// Arbitrates one shared countdown timer among NUM_REQ requesters: lookup, load, 1 Hz countdown, expiry pulse.
// Define TIMER_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module timer_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int SEL_W   = 2,
    parameter int VALUE_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*SEL_W-1:0] req_interval,
    input  logic                     hold,
    input  logic                     one_hz_enable,
    input  logic [VALUE_W-1:0]       param_value,
    output logic [SEL_W-1:0]         param_interval,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       expired,
    output logic                     busy,
    output logic [VALUE_W-1:0]       remaining
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_LOAD,
        S_COUNT,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]     interval_q, interval_d;
    logic [VALUE_W-1:0]   remaining_q, remaining_d;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic                 owner_req;

`ifdef TIMER_ARB_FIXED_PRIO_EN
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand_idx;
    int               cand;

    // Search starts one past the last winner and wraps, so every waiting requester is reached.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr_q) + k) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end
`endif

    assign owner_req = |(req & grant_q);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        interval_d  = interval_q;
        remaining_d = remaining_q;
`ifndef TIMER_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        if ((state_q inside {S_LOOKUP, S_LOAD, S_COUNT}) && !owner_req) begin
            // Owner abandoned the job; this beats a coincident final tick.
            state_d     = S_IDLE;
            grant_d     = '0;
            remaining_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!hold && win_found) begin
                        grant_d          = '0;
                        grant_d[win_idx] = 1'b1;
                        interval_d       = req_interval[int'(win_idx)*SEL_W +: SEL_W];
`ifndef TIMER_ARB_FIXED_PRIO_EN
                        ptr_d            = win_idx;
`endif
                        state_d          = S_LOOKUP;
                    end
                end
                S_LOOKUP: state_d = S_LOAD;
                S_LOAD: begin
                    remaining_d = param_value;
                    state_d     = (param_value == '0) ? S_DONE : S_COUNT;
                end
                S_COUNT: begin
                    if (one_hz_enable && remaining_q != '0) begin
                        remaining_d = remaining_q - VALUE_W'(1);
                        if (remaining_q == VALUE_W'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            interval_q  <= '0;
            remaining_q <= '0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
            ptr_q       <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            interval_q  <= interval_d;
            remaining_q <= remaining_d;
`ifndef TIMER_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign param_interval = interval_q;
    assign grant          = grant_q;
    assign expired        = (state_q == S_DONE) ? grant_q : '0;
    assign busy           = (state_q != S_IDLE);
    assign remaining      = remaining_q;

endmodule
